mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 SHALL provide the following ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instruction is mult/multu/div/divu (decode aluchose)
- md_op  in  3  decode aluOp: 000 mult, 001 multu, 010 div, 011 divu; other values = no-op
- mthi  in  1  write A into HI (decode changeHI)
- mtlo  in  1  write A into LO (decode changeLO)
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- req  in  1  exception/interrupt flush of E-stage instruction this cycle
- busy  out  1  operation in flight
- md_stall  out  1  start | busy; consumed by hazard unit with decode mult_relative
- HI  out  32  architectural HI
- LO  out  32  architectural LO

Function
REQ-003 SHALL have two states, IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-004 In IDLE with start=1, req=0 and a valid md_op, SHALL compute the result into internal hi_tmp/lo_tmp at the edge, load cnt=5 (mult/multu) or cnt=10 (div/divu), and enter BUSY.
REQ-005 In BUSY, each edge SHALL decrement cnt; the edge at cnt==1 SHALL write HI<=hi_tmp and LO<=lo_tmp and return to IDLE.
REQ-006 busy SHALL be high for exactly 5 (mult) or 10 (div) cycles after the start edge; new HI/LO values SHALL be visible in the first cycle busy=0.
REQ-007 mult SHALL produce the signed 64-bit product {HI,LO}; multu SHALL produce the unsigned 64-bit product.
REQ-008 div SHALL produce a signed quotient truncated toward zero in LO and a remainder in HI that takes the dividend's sign. divu SHALL produce the unsigned quotient in LO and the unsigned remainder in HI.
REQ-009 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-010 div/divu with B==0 SHALL still run the full 10 busy cycles and leave HI/LO unchanged.
REQ-011 In IDLE with start=0 and req=0, mthi SHALL set HI<=A at the edge and mtlo SHALL set LO<=A at the edge.
REQ-012 If mthi and mtlo are both high, both writes SHALL occur.
REQ-013 start, mthi and mtlo SHALL be ignored while BUSY; the hazard unit guarantees they do not occur.
REQ-014 req=1 in the same cycle as start/mthi/mtlo SHALL suppress that operation: no state change, HI/LO unchanged.
REQ-015 req during BUSY SHALL NOT abort the operation, because the in-flight instruction has already committed past E.
REQ-016 md_stall SHALL be combinational: start | busy.
REQ-017 HI and LO SHALL be driven directly from registers, not through combinational logic.

Reset
REQ-018 While reset=1 at an edge, SHALL force state=IDLE, cnt=0, busy=0, HI=0, LO=0, hi_tmp=0, lo_tmp=0.
REQ-019 Reset SHALL take priority over all other inputs; reset mid-operation SHALL discard the pending result.

Structure
REQ-020 A shared package SHALL hold the md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the constants MULT_CYCLES=5 and DIV_CYCLES=10.
REQ-021 The block SHALL be a single module with no sub-module; the arithmetic is inline combinational logic feeding hi_tmp/lo_tmp.

Verification
REQ-022 mult, A=0xFFFFFFFE, B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-023 multu, same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-024 div, A=-7 (0xFFFFFFF9), B=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu, A=7, B=0 -> 10 busy cycles, HI/LO unchanged.
REQ-025 mthi A=0x1234 with req=1 -> HI unchanged. mtlo A=0x55 with req=0 -> LO=0x55 next cycle. start together with req -> busy stays 0.
REQ-026 Start div, assert reset at busy cycle 4 -> next cycle busy=0, HI=LO=0, and no late write-back. Start mult, pulse req at busy cycle 2 -> result still written after 5 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit.
// Holds the md_op encodings, the FSM state type and the busy-cycle counts
// for multiply and divide operations.
package mult_div_unit_pkg;

    // md_op encodings as delivered by decode (aluOp); other values are no-ops
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Number of cycles busy stays high after the start edge
    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    // True for the four encodings that launch an operation
    function automatic logic md_op_valid(input logic [2:0] op);
        logic ok;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True for div/divu
    function automatic logic md_op_is_div(input logic [2:0] op);
        logic d;
        case (op)
            MD_DIV, MD_DIVU: d = 1'b1;
            default:         d = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit for the E stage.
// The result is computed combinationally and captured into hi_tmp/lo_tmp at
// the start edge; the architectural HI/LO registers are updated only when the
// fixed busy window (5 cycles mult, 10 cycles div) expires, mimicking a
// multi-cycle arithmetic unit.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, md_op    launch mult/multu/div/divu (md_op selects)
//   mthi, mtlo      move A into HI / LO
//   A, B            forwarded rs / rt operands
//   req             exception flush of the E-stage instruction this cycle
//   busy            operation in flight (registered)
//   md_stall        start | busy, combinational, for the hazard unit
//   HI, LO          architectural HI / LO (registered)
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        busy_r, busy_s;
    logic [31:0] hi_r, hi_s;
    logic [31:0] lo_r, lo_s;
    logic [31:0] hi_tmp_r, hi_tmp_s;
    logic [31:0] lo_tmp_r, lo_tmp_s;
    // Cleared for divide-by-zero so the final edge leaves HI/LO untouched
    logic        wb_en_r, wb_en_s;

    // Arithmetic datapath
    logic        op_signed_s;
    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic [63:0] prod_s;
    logic        b_zero_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_div_s;
    logic [31:0] mag_q_s;
    logic [31:0] mag_r_s;
    logic [31:0] udiv_q_s;
    logic [31:0] udiv_r_s;
    logic [31:0] sdiv_q_s;
    logic [31:0] sdiv_r_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    // Multiply and divide operands and results for the current inputs
    always_comb begin
        op_signed_s = (md_op == MD_MULT) || (md_op == MD_DIV);
        // Sign-extending to 64 bits makes the low 64 bits of the product
        // correct for both signed and unsigned operands
        a_ext_s = {{32{A[31] & op_signed_s}}, A};
        b_ext_s = {{32{B[31] & op_signed_s}}, B};
        prod_s  = a_ext_s * b_ext_s;

        b_zero_s = (B == 32'd0);
        // Divisor forced to 1 on zero so the divider never sees 0; the
        // result is discarded in that case anyway
        b_div_s  = b_zero_s ? 32'd1 : B;
        udiv_q_s = A / b_div_s;
        udiv_r_s = A % b_div_s;

        // Signed divide on magnitudes: quotient truncates toward zero and the
        // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
        // magnitude 0x80000000 with positive sign, i.e. 0x80000000, rem 0.
        a_mag_s  = A[31] ? (32'd0 - A) : A;
        b_mag_s  = B[31] ? (32'd0 - B) : B;
        mag_q_s  = a_mag_s / (b_zero_s ? 32'd1 : b_mag_s);
        mag_r_s  = a_mag_s % (b_zero_s ? 32'd1 : b_mag_s);
        sdiv_q_s = (A[31] ^ B[31]) ? (32'd0 - mag_q_s) : mag_q_s;
        sdiv_r_s = A[31] ? (32'd0 - mag_r_s) : mag_r_s;

        case (md_op)
            MD_MULT, MD_MULTU: begin
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
            end
            MD_DIV: begin
                res_hi_s = sdiv_r_s;
                res_lo_s = sdiv_q_s;
            end
            MD_DIVU: begin
                res_hi_s = udiv_r_s;
                res_lo_s = udiv_q_s;
            end
            default: begin
                res_hi_s = 32'd0;
                res_lo_s = 32'd0;
            end
        endcase
    end

    // Next-state logic for the IDLE/BUSY controller and HI/LO registers
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        busy_s   = busy_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        hi_tmp_s = hi_tmp_r;
        lo_tmp_s = lo_tmp_r;
        wb_en_s  = wb_en_r;
        case (state_r)
            IDLE: begin
                if (!req && start && md_op_valid(md_op)) begin
                    hi_tmp_s = res_hi_s;
                    lo_tmp_s = res_lo_s;
                    wb_en_s  = !(md_op_is_div(md_op) && b_zero_s);
                    cnt_s    = md_op_is_div(md_op) ? DIV_CYCLES : MULT_CYCLES;
                    busy_s   = 1'b1;
                    state_s  = BUSY;
                end else if (!req && !start) begin
                    if (mthi) begin
                        hi_s = A;
                    end else begin
                        hi_s = hi_r;
                    end
                    if (mtlo) begin
                        lo_s = A;
                    end else begin
                        lo_s = lo_r;
                    end
                end else begin
                    // Flushed or invalid launch: nothing changes
                    state_s = IDLE;
                end
            end
            BUSY: begin
                // start/mthi/mtlo/req are ignored here; the op has committed
                if (cnt_r <= 4'd1) begin
                    cnt_s   = 4'd0;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                    if (wb_en_r) begin
                        hi_s = hi_tmp_r;
                        lo_s = lo_tmp_r;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            busy_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            hi_tmp_r <= 32'd0;
            lo_tmp_r <= 32'd0;
            wb_en_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            hi_tmp_r <= hi_tmp_s;
            lo_tmp_r <= lo_tmp_s;
            wb_en_r  <= wb_en_s;
        end
    end

    assign busy     = busy_r;
    assign md_stall = start | busy_r;
    assign HI       = hi_r;
    assign LO       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the stimulus pushes the expected
// HI/LO and busy length of every launched operation; a monitor compares them
// on the first cycle busy drops.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   busy_cnt = 0;
    logic prev_busy = 1'b0;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .A        (A),
        .B        (B),
        .req      (req),
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles and score each completion against the queue
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cnt++;
        end else if (prev_busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_HI", HI, mon_e.hi);
                check("done_LO", LO, mon_e.lo);
                check("busy_cycles", 32'(busy_cnt), 32'(mon_e.cycles));
            end
            busy_cnt = 0;
        end
        prev_busy = busy;
    end

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.cycles = cyc;
        exp_q.push_back(e);
    endtask

    // Present a start for one cycle; returns #1 after the start edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        push(hi, lo, cyc);
        issue(op, a, b);
        wait_cycles(cyc + 2);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'b000;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        req   = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_HI", HI, 32'd0);
        check("reset_LO", LO, 32'd0);
        @(posedge clk);
        #1;

        // Directed operations with hand-computed results
        run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);   // mult
        run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);   // multu
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);  // div -7/2
        run_op(3'b011, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);          // divu by 0
        run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10);                       // divu
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);  // div overflow
        run_op(3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);          // div 7/-2
        run_op(3'b000, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5);           // mult 2^32

        // mthi flushed by req: HI keeps 1
        mthi = 1'b1; A = 32'h1234; req = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; req = 1'b0;
        @(negedge clk);
        check("mthi_req_HI", HI, 32'd1);

        // mtlo normal
        @(posedge clk); #1;
        mtlo = 1'b1; A = 32'h55;
        @(posedge clk); #1;
        mtlo = 1'b0;
        @(negedge clk);
        check("mtlo_LO", LO, 32'h55);
        check("mtlo_HI_kept", HI, 32'd1);

        // mthi and mtlo together
        @(posedge clk); #1;
        mthi = 1'b1; mtlo = 1'b1; A = 32'hABCD;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        @(negedge clk);
        check("both_HI", HI, 32'hABCD);
        check("both_LO", LO, 32'hABCD);

        // start together with req: no launch
        @(posedge clk); #1;
        start = 1'b1; md_op = 3'b000; A = 32'd9; B = 32'd9; req = 1'b1;
        @(negedge clk);
        check("stall_on_start", {31'd0, md_stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; req = 1'b0;
        @(negedge clk);
        check("start_req_busy", {31'd0, busy}, 32'd0);
        check("start_req_HI", HI, 32'hABCD);
        @(posedge clk); #1;

        // mult with req pulse in busy cycle 2: result still lands
        push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
        issue(3'b000, 32'd5, 32'hFFFF_FFFD);
        @(posedge clk); #1;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_cycles(6);

        // div aborted by reset in busy cycle 4
        push(32'd0, 32'd0, 4);
        issue(3'b010, 32'd100, 32'd7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_cycles(12);
        @(negedge clk);
        check("no_late_wb_HI", HI, 32'd0);
        check("no_late_wb_LO", LO, 32'd0);
        check("no_late_wb_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // invalid md_op does not launch
        issue(3'b100, 32'd3, 32'd4);
        @(negedge clk);
        check("invalid_op_busy", {31'd0, busy}, 32'd0);
        wait_cycles(3);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
